// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - shared types and encodings for the multicycle main controller
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_ADDIEX = 4'd8,
        S_ADDIWB = 4'd9,
        S_BRANCH = 4'd10,
        S_JUMP   = 4'd11,
        S_JAL    = 4'd12,
        S_TRAP   = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       mem_req;
        logic       iord;
        logic       we_mem;
        logic       ir_we;
        logic       pc_we;
        logic       branch;
        logic       reg_dst;
        logic       mem2reg;
        logic       we_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
        logic       wd_sel;
        logic       wa_sel;
    } ctrl_t;

    // Opcode dispatch out of DECODE; unsupported opcodes land in TRAP.
    function automatic state_t decode_op(input logic [5:0] op);
        case (op)
            OP_RTYPE:     decode_op = S_EXEC;
            OP_ADDI:      decode_op = S_ADDIEX;
            OP_BEQ:       decode_op = S_BRANCH;
            OP_J:         decode_op = S_JUMP;
            OP_JAL:       decode_op = S_JAL;
            OP_LW, OP_SW: decode_op = S_MEMADR;
            default:      decode_op = S_TRAP;
        endcase
    endfunction

endpackage

// File: rtl/mc_ctrl_if.sv
// rtl/mc_ctrl_if.sv - controller-to-datapath control bus with memory handshake
interface mc_ctrl_if;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       mem_req;
    logic       iord;
    logic       we_mem;
    logic       ir_we;
    logic       pc_we;
    logic       branch;
    logic       reg_dst;
    logic       mem2reg;
    logic       we_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
    logic       wd_sel;
    logic       wa_sel;

    modport master (
        input  opcode, mem_ready,
        output mem_req, iord, we_mem, ir_we, pc_we, branch, reg_dst, mem2reg,
               we_reg, alu_src_a, alu_src_b, alu_op, pc_src, wd_sel, wa_sel
    );

    modport slave (
        output opcode, mem_ready,
        input  mem_req, iord, we_mem, ir_we, pc_we, branch, reg_dst, mem2reg,
               we_reg, alu_src_a, alu_src_b, alu_op, pc_src, wd_sel, wa_sel
    );
endinterface

// File: rtl/mc_ctrl_outdec.sv
// rtl/mc_ctrl_outdec.sv - state to control-word decoder
module mc_ctrl_outdec
    import mc_ctrl_pkg::*;
(
    input  state_t state,
    input  logic   mem_ready,
    input  logic   rst_n,
    output ctrl_t  cw
);

    // Moore decode of state; only the FETCH IR/PC loads follow mem_ready, and reset masks every enable.
    always_comb begin
        cw = '0;
        case (state)
            S_FETCH: begin
                cw.mem_req   = 1'b1;
                cw.alu_src_b = SRCB_FOUR;
                cw.alu_op    = ALU_ADD;
                cw.pc_src    = PCSRC_ALU;
                cw.ir_we     = mem_ready;
                cw.pc_we     = mem_ready;
            end
            S_DECODE: begin
                cw.alu_src_b = SRCB_IMM_SH;
                cw.alu_op    = ALU_ADD;
            end
            S_MEMADR, S_ADDIEX: begin
                cw.alu_src_a = 1'b1;
                cw.alu_src_b = SRCB_IMM;
                cw.alu_op    = ALU_ADD;
            end
            S_MEMRD: begin
                cw.mem_req = 1'b1;
                cw.iord    = 1'b1;
            end
            S_MEMWB: begin
                cw.we_reg  = 1'b1;
                cw.mem2reg = 1'b1;
            end
            S_MEMWR: begin
                cw.mem_req = 1'b1;
                cw.iord    = 1'b1;
                cw.we_mem  = 1'b1;
            end
            S_EXEC: begin
                cw.alu_src_a = 1'b1;
                cw.alu_src_b = SRCB_RT;
                cw.alu_op    = ALU_FUNCT;
            end
            S_ALUWB: begin
                cw.we_reg  = 1'b1;
                cw.reg_dst = 1'b1;
            end
            S_ADDIWB: begin
                cw.we_reg = 1'b1;
            end
            S_BRANCH: begin
                cw.alu_src_a = 1'b1;
                cw.alu_src_b = SRCB_RT;
                cw.alu_op    = ALU_SUB;
                cw.pc_src    = PCSRC_ALUOUT;
                cw.branch    = 1'b1;
            end
            S_JUMP: begin
                cw.pc_src = PCSRC_JUMP;
                cw.pc_we  = 1'b1;
            end
            S_JAL: begin
                cw.pc_src = PCSRC_JUMP;
                cw.pc_we  = 1'b1;
                cw.we_reg = 1'b1;
                cw.wd_sel = 1'b1;
                cw.wa_sel = 1'b1;
            end
            default: begin
                cw = '0;
            end
        endcase
        if (!rst_n) begin
            cw.mem_req = 1'b0;
            cw.we_mem  = 1'b0;
            cw.ir_we   = 1'b0;
            cw.pc_we   = 1'b0;
            cw.branch  = 1'b0;
            cw.we_reg  = 1'b0;
        end
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// rtl/mc_ctrl_fsm.sv - multicycle MIPS main controller with retired-instruction counter
module mc_ctrl_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    mc_ctrl_if.master        bus,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    state_t state;
    state_t next_state;
    ctrl_t  cw;

    // Next-state selection; the memory states wait on mem_ready, others advance unconditionally.
    always_comb begin
        next_state = state;
        case (state)
            S_FETCH:  next_state = bus.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: next_state = decode_op(bus.opcode);
            S_MEMADR: next_state = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  next_state = bus.mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:  next_state = bus.mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   next_state = S_ALUWB;
            S_ADDIEX: next_state = S_ADDIWB;
            S_TRAP:   next_state = S_TRAP;
            default:  next_state = S_FETCH;
        endcase
    end

    // State, retire counter and sticky illegal flag; an instruction retires when control returns to FETCH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_FETCH;
            retired <= '0;
            illegal <= 1'b0;
        end else begin
            state <= next_state;
            if (state != S_FETCH && next_state == S_FETCH) begin
                retired <= retired + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (next_state == S_TRAP) begin
                illegal <= 1'b1;
            end
        end
    end

    mc_ctrl_outdec u_outdec (
        .state     (state),
        .mem_ready (bus.mem_ready),
        .rst_n     (rst_n),
        .cw        (cw)
    );

    assign bus.mem_req   = cw.mem_req;
    assign bus.iord      = cw.iord;
    assign bus.we_mem    = cw.we_mem;
    assign bus.ir_we     = cw.ir_we;
    assign bus.pc_we     = cw.pc_we;
    assign bus.branch    = cw.branch;
    assign bus.reg_dst   = cw.reg_dst;
    assign bus.mem2reg   = cw.mem2reg;
    assign bus.we_reg    = cw.we_reg;
    assign bus.alu_src_a = cw.alu_src_a;
    assign bus.alu_src_b = cw.alu_src_b;
    assign bus.alu_op    = cw.alu_op;
    assign bus.pc_src    = cw.pc_src;
    assign bus.wd_sel    = cw.wd_sel;
    assign bus.wa_sel    = cw.wa_sel;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb/tb_mc_ctrl_fsm.sv - scoreboard bench for the multicycle main controller
module tb_mc_ctrl_fsm;

    localparam int CNT_W = 4;

    // {mem_req,iord,we_mem,ir_we,pc_we,branch,reg_dst,mem2reg,we_reg,alu_src_a}_{srcb}_{aluop}_{pcsrc}_{wd_sel,wa_sel}
    localparam logic [17:0] W_RST    = 18'b0000000000_01_00_00_00;
    localparam logic [17:0] W_FETCH1 = 18'b1001100000_01_00_00_00;
    localparam logic [17:0] W_FETCH0 = 18'b1000000000_01_00_00_00;
    localparam logic [17:0] W_DECODE = 18'b0000000000_11_00_00_00;
    localparam logic [17:0] W_MEMADR = 18'b0000000001_10_00_00_00;
    localparam logic [17:0] W_MEMRD  = 18'b1100000000_00_00_00_00;
    localparam logic [17:0] W_MEMWB  = 18'b0000000110_00_00_00_00;
    localparam logic [17:0] W_MEMWR  = 18'b1110000000_00_00_00_00;
    localparam logic [17:0] W_EXEC   = 18'b0000000001_00_10_00_00;
    localparam logic [17:0] W_ALUWB  = 18'b0000001010_00_00_00_00;
    localparam logic [17:0] W_ADDIEX = 18'b0000000001_10_00_00_00;
    localparam logic [17:0] W_ADDIWB = 18'b0000000010_00_00_00_00;
    localparam logic [17:0] W_BRANCH = 18'b0000010001_00_01_01_00;
    localparam logic [17:0] W_JUMP   = 18'b0000100000_00_00_10_00;
    localparam logic [17:0] W_JAL    = 18'b0000100010_00_00_10_11;
    localparam logic [17:0] W_TRAP   = 18'b0000000000_00_00_00_00;

    localparam logic [5:0] R = 6'b000000, ADDI = 6'b001000, BEQ = 6'b000100;
    localparam logic [5:0] J = 6'b000010, JAL = 6'b000011, LW = 6'b100011;
    localparam logic [5:0] SW = 6'b101011, BAD = 6'b111111;

    typedef struct {
        logic [17:0]      cw;
        logic             ill;
        logic [CNT_W-1:0] ret;
        string            tag;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             illegal;
    logic [CNT_W-1:0] retired;

    mc_ctrl_if bus ();

    mc_ctrl_fsm #(.CNT_W(CNT_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .illegal (illegal),
        .retired (retired)
    );

    always #5 clk = ~clk;

    exp_t             sb[$];
    int               total = 0;
    int               bad = 0;
    logic             exp_ill = 1'b0;
    logic [CNT_W-1:0] exp_ret = '0;

    task automatic cyc(input logic r, input logic [5:0] op, input logic mr,
                       input logic [17:0] cw, input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n = r;
        bus.opcode = op;
        bus.mem_ready = mr;
        e.cw = cw;
        e.ill = exp_ill;
        e.ret = exp_ret;
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic retire();
        exp_ret = exp_ret + 1'b1;
    endtask

    // Monitor: mid-cycle, pop the expected response for this cycle and compare it with the bus.
    initial begin
        exp_t        e;
        logic [17:0] act;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                act = {bus.mem_req, bus.iord, bus.we_mem, bus.ir_we, bus.pc_we, bus.branch,
                       bus.reg_dst, bus.mem2reg, bus.we_reg, bus.alu_src_a, bus.alu_src_b,
                       bus.alu_op, bus.pc_src, bus.wd_sel, bus.wa_sel};
                total++;
                if (act !== e.cw) begin
                    bad++;
                    $display("FAIL %s ctrl got=%b want=%b", e.tag, act, e.cw);
                end
                total++;
                if (illegal !== e.ill) begin
                    bad++;
                    $display("FAIL %s illegal got=%b want=%b", e.tag, illegal, e.ill);
                end
                total++;
                if (retired !== e.ret) begin
                    bad++;
                    $display("FAIL %s retired got=%0d want=%0d", e.tag, retired, e.ret);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.opcode = R;
        bus.mem_ready = 1'b0;

        cyc(0, R, 1, W_RST, "reset");
        cyc(1, R, 1, W_FETCH1, "r_fetch");
        cyc(1, R, 1, W_DECODE, "r_decode");
        cyc(1, R, 1, W_EXEC, "r_exec");
        cyc(1, R, 1, W_ALUWB, "r_aluwb");
        retire();

        cyc(1, LW, 1, W_FETCH1, "lw_fetch");
        cyc(1, LW, 1, W_DECODE, "lw_decode");
        cyc(1, LW, 1, W_MEMADR, "lw_memadr");
        cyc(1, LW, 0, W_MEMRD, "lw_memrd_w0");
        cyc(1, LW, 0, W_MEMRD, "lw_memrd_w1");
        cyc(1, LW, 1, W_MEMRD, "lw_memrd_go");
        cyc(1, LW, 1, W_MEMWB, "lw_memwb");
        retire();

        cyc(1, SW, 1, W_FETCH1, "sw_fetch");
        cyc(1, SW, 0, W_DECODE, "sw_decode_mr0");
        cyc(1, SW, 0, W_MEMADR, "sw_memadr_mr0");
        cyc(1, SW, 1, W_MEMWR, "sw_memwr");
        retire();

        cyc(1, ADDI, 0, W_FETCH0, "addi_fetch_stall");
        cyc(1, ADDI, 1, W_FETCH1, "addi_fetch");
        cyc(1, ADDI, 1, W_DECODE, "addi_decode");
        cyc(1, ADDI, 1, W_ADDIEX, "addi_ex");
        cyc(1, ADDI, 1, W_ADDIWB, "addi_wb");
        retire();

        cyc(1, BEQ, 1, W_FETCH1, "beq_fetch");
        cyc(1, BEQ, 1, W_DECODE, "beq_decode");
        cyc(1, BEQ, 1, W_BRANCH, "beq_branch");
        retire();
        cyc(1, JAL, 1, W_FETCH1, "jal_fetch");
        cyc(1, JAL, 1, W_DECODE, "jal_decode");
        cyc(1, JAL, 1, W_JAL, "jal_jal");
        retire();
        cyc(1, J, 1, W_FETCH1, "j_fetch");
        cyc(1, J, 1, W_DECODE, "j_decode");
        cyc(1, J, 1, W_JUMP, "j_jump");
        retire();

        cyc(1, BAD, 1, W_FETCH1, "bad_fetch");
        cyc(1, BAD, 1, W_DECODE, "bad_decode");
        exp_ill = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cyc(1, BAD, logic'(i % 2), W_TRAP, "trap_hold");
        end
        exp_ill = 1'b0;
        exp_ret = '0;
        cyc(0, BAD, 1, W_RST, "trap_reset");

        for (int i = 0; i < 16; i++) begin
            cyc(1, ADDI, 1, W_FETCH1, "wrap_fetch");
            cyc(1, ADDI, 1, W_DECODE, "wrap_decode");
            cyc(1, ADDI, 1, W_ADDIEX, "wrap_ex");
            cyc(1, ADDI, 1, W_ADDIWB, "wrap_wb");
            retire();
        end
        cyc(1, SW, 1, W_FETCH1, "wrapped_fetch");
        cyc(1, SW, 1, W_DECODE, "abort_decode");
        cyc(1, SW, 1, W_MEMADR, "abort_memadr");
        cyc(1, SW, 0, W_MEMWR, "abort_memwr");
        exp_ret = '0;
        cyc(0, SW, 0, W_RST, "abort_reset");

        cyc(1, R, 1, W_FETCH1, "post_fetch");
        cyc(1, R, 1, W_DECODE, "post_decode");
        cyc(1, R, 1, W_EXEC, "post_exec");
        cyc(1, R, 1, W_ALUWB, "post_aluwb");
        retire();
        cyc(1, R, 0, W_FETCH0, "post_retired");

        repeat (2) @(posedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain left=%0d want=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
